// File: rtl/router_pkg.sv
// router_pkg: shared types, field widths and header packing for the router packet source.
package router_pkg;

    typedef enum logic [2:0] {IDLE, FILL, HDR, PLD, PAR, GAP} state_t;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

    function automatic logic [DATA_W-1:0] pack_header(input logic [LEN_W-1:0] len,
                                                      input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// router_tx_buf: 64x8 first-word-fall-through payload FIFO with flush and occupancy count.
module router_tx_buf
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic [6:0]        count
);

    // one extra pointer bit distinguishes full from empty
    logic [6:0]        wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem [64];

    assign count   = wr_ptr - rd_ptr;
    assign empty   = count == 7'd0;
    assign rd_data = mem[rd_ptr[5:0]];

    always_ff @(posedge clock) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 7'd1;
            if (pop) rd_ptr <= rd_ptr + 7'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[5:0]] <= wr_data;
    end

endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a host payload, then drives header, payload and parity into the router,
// stalling on busy and leaving a fixed idle gap between packets.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [DATA_W-1:0] pl_data,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_in,
    output logic              cmd_err,
    output logic              tx_done,
    output logic [CNT_W-1:0]  pkt_count
);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [LEN_W-1:0]    len_q, len_n;
    logic [DATA_W-1:0]   parity, parity_n, data_n;
    logic                valid_n, err_n, done_n;
    logic [CNT_W-1:0]    count_n;
    logic [7:0]          gap_cnt, gap_n;
    logic                push, pop, flush, empty, legal;
    logic [DATA_W-1:0]   rd_data;
    logic [6:0]          fill;

    router_tx_buf u_buf (
        .clock  (clock),
        .resetn (resetn),
        .flush  (flush),
        .push   (push),
        .pop    (pop),
        .wr_data(pl_data),
        .rd_data(rd_data),
        .empty  (empty),
        .count  (fill)
    );

    assign legal     = cmd_addr != ADDR_ILLEGAL && cmd_len != '0 && cmd_len <= LEN_W'(MAX_LEN);
    assign cmd_ready = state == IDLE && resetn;
    assign pl_ready  = state == FILL && fill < {1'b0, len_q};

    always_comb begin
        state_n  = state;
        addr_n   = addr_q;
        len_n    = len_q;
        parity_n = parity;
        data_n   = data_in;
        valid_n  = pkt_valid;
        err_n    = 1'b0;
        done_n   = 1'b0;
        count_n  = pkt_count;
        gap_n    = gap_cnt;
        push     = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                if (legal) begin
                    addr_n  = cmd_addr;
                    len_n   = cmd_len;
                    flush   = 1'b1;
                    state_n = FILL;
                end else err_n = 1'b1;
            end
            FILL: if (pl_valid && pl_ready) begin
                push = 1'b1;
                if (fill + 7'd1 == {1'b0, len_q}) begin
                    valid_n = 1'b1;
                    data_n  = pack_header(len_q, addr_q);
                    state_n = HDR;
                end
            end
            HDR: if (!busy) begin
                parity_n = data_in;
                data_n   = rd_data;
                pop      = 1'b1;
                state_n  = PLD;
            end
            // the byte on data_in was already popped, so an empty buffer means it is the last one
            PLD: if (!busy) begin
                parity_n = parity ^ data_in;
                if (empty) begin
                    valid_n = 1'b0;
                    data_n  = parity ^ data_in;
                    state_n = PAR;
                end else begin
                    data_n = rd_data;
                    pop    = 1'b1;
                end
            end
            PAR: if (!busy) begin
                done_n  = 1'b1;
                count_n = pkt_count + CNT_W'(1);
                data_n  = '0;
                gap_n   = '0;
                state_n = GAP;
            end
            GAP: begin
                gap_n   = gap_cnt + 8'd1;
                state_n = gap_cnt == 8'(GAP_CYCLES - 1) ? IDLE : GAP;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            parity    <= '0;
            data_in   <= '0;
            pkt_valid <= 1'b0;
            cmd_err   <= 1'b0;
            tx_done   <= 1'b0;
            pkt_count <= '0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_n;
            addr_q    <= addr_n;
            len_q     <= len_n;
            parity    <= parity_n;
            data_in   <= data_n;
            pkt_valid <= valid_n;
            cmd_err   <= err_n;
            tx_done   <= done_n;
            pkt_count <= count_n;
            gap_cnt   <= gap_n;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: randomized and directed packets checked every cycle against a byte-stream model.
module tb_router_pkt_tx;

    localparam int GAP = 2;

    logic        clock = 1'b0, resetn = 1'b0, cmd_valid = 1'b0, pl_valid = 1'b0, busy = 1'b0;
    logic [1:0]  cmd_addr = '0;
    logic [5:0]  cmd_len = '0;
    logic [7:0]  pl_data = '0;
    logic        cmd_ready, pl_ready, pkt_valid, cmd_err, tx_done;
    logic [7:0]  data_in;
    logic [15:0] pkt_count;

    int total = 0, bad = 0;
    bit rand_busy = 0;

    // model: 0 idle, 1 collecting payload, 2 streaming, 3 gap
    int          mode = 0, sidx = 0, gap_left = 0;
    logic [5:0]  m_len = '0;
    logic [1:0]  m_addr = '0;
    logic [7:0]  pay[$], stream[$];
    bit          m_err = 0, m_done = 0;
    logic [15:0] m_cnt = '0;
    int          send_cycles = 0, hdr_cycles = 0, err_pulses = 0, last_gap = 0, quiet = 0;
    bit          seen_pkt = 0;

    router_pkt_tx #(.MAX_LEN(63), .GAP_CYCLES(GAP), .CNT_W(16)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .pl_valid (pl_valid),
        .pl_ready (pl_ready),
        .pl_data  (pl_data),
        .busy     (busy),
        .pkt_valid(pkt_valid),
        .data_in  (data_in),
        .cmd_err  (cmd_err),
        .tx_done  (tx_done),
        .pkt_count(pkt_count)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [7:0] p;
        m_err  = 0;
        m_done = 0;
        if (!resetn) begin
            mode = 0;
            pay.delete();
            stream.delete();
            m_cnt = '0;
            return;
        end
        case (mode)
            0: if (cmd_valid) begin
                if (cmd_addr != 2'd3 && cmd_len != 6'd0) begin
                    mode   = 1;
                    m_len  = cmd_len;
                    m_addr = cmd_addr;
                    pay.delete();
                end else m_err = 1;
            end
            1: if (pl_valid && pay.size() < int'(m_len)) begin
                pay.push_back(pl_data);
                if (pay.size() == int'(m_len)) begin
                    stream.delete();
                    p = {m_len, m_addr};
                    stream.push_back(p);
                    foreach (pay[i]) begin
                        stream.push_back(pay[i]);
                        p ^= pay[i];
                    end
                    stream.push_back(p);
                    sidx = 0;
                    mode = 2;
                end
            end
            2: if (!busy) begin
                sidx++;
                if (sidx == stream.size()) begin
                    m_done = 1;
                    m_cnt++;
                    mode = 3;
                    gap_left = GAP;
                end
            end
            default: begin
                gap_left--;
                if (gap_left == 0) mode = 0;
            end
        endcase
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        check("pkt_valid", pkt_valid, mode == 2 && sidx < stream.size() - 1);
        check("data_in", data_in, mode == 2 ? stream[sidx] : 8'h00);
        check("cmd_ready", cmd_ready, mode == 0 && resetn);
        check("pl_ready", pl_ready, mode == 1 && pay.size() < int'(m_len));
        check("cmd_err", cmd_err, m_err);
        check("tx_done", tx_done, m_done);
        check("pkt_count", pkt_count, m_cnt);
        if (cmd_err) err_pulses++;
        if (mode == 2) begin
            send_cycles++;
            if (sidx == 0) begin
                hdr_cycles++;
                if (quiet > 0 && seen_pkt) last_gap = quiet;
                seen_pkt = 1;
            end
            quiet = 0;
        end else quiet++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #2;
        if (rand_busy) busy = ($urandom % 3) == 0;
    endtask

    task automatic send_cmd(input logic [1:0] a, input logic [5:0] l);
        int n = 0;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1;
        pl_valid  = rand_busy ? ($urandom % 2) == 1 : 1'b0;
        pl_data   = 8'($urandom);
        while (!cmd_ready && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) check("cmd_ready_timeout", 0, 1);
        tick();
        cmd_valid = 0;
        pl_valid  = 0;
    endtask

    task automatic send_pay(input logic [7:0] d[$], input bit gaps);
        for (int i = 0; i < d.size(); i++) begin
            int n = 0;
            pl_data  = d[i];
            pl_valid = gaps ? ($urandom % 2) == 1 : 1'b1;
            while (!(pl_valid && pl_ready) && n < 500) begin
                tick();
                n++;
                pl_valid = gaps ? ($urandom % 2) == 1 : 1'b1;
            end
            if (n >= 500) check("pl_ready_timeout", 0, 1);
            tick();
        end
        pl_valid = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!tx_done && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) check("tx_done_timeout", 0, 1);
    endtask

    initial begin
        logic [7:0] q[$], r[$];
        logic [1:0] a;
        logic [5:0] l;
        resetn = 0;
        repeat (3) tick();
        check("rst_pkt_valid", pkt_valid, 0);
        check("rst_data_in", data_in, 0);
        check("rst_count", pkt_count, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        resetn = 1;
        tick();
        check("idle_cmd_ready", cmd_ready, 1);

        q = '{8'hA1, 8'hB2, 8'hC3};
        send_cycles = 0;
        send_cmd(2'd1, 6'd3);
        send_pay(q, 0);
        wait_done();
        check("basic_hdr", stream[0], 8'h0D);
        check("basic_par", stream[4], 8'hDD);
        check("basic_cycles", send_cycles, 5);
        check("basic_count", pkt_count, 1);

        send_cycles = 0;
        hdr_cycles  = 0;
        send_cmd(2'd1, 6'd3);
        send_pay(q, 0);
        tick();
        busy = 1;
        tick();
        busy = 0;
        tick();
        busy = 1;
        repeat (3) tick();
        busy = 0;
        wait_done();
        check("stall_cycles", send_cycles, 9);
        check("stall_hdr_cycles", hdr_cycles, 1);
        check("stall_par", stream[4], 8'hDD);
        check("stall_count", pkt_count, 2);

        err_pulses = 0;
        send_cmd(2'd3, 6'd5);
        send_cmd(2'd0, 6'd0);
        tick();
        tick();
        check("illegal_errs", err_pulses, 2);
        check("illegal_count", pkt_count, 2);

        q.delete();
        for (int i = 0; i < 63; i++) q.push_back(8'(i));
        send_cycles = 0;
        send_cmd(2'd2, 6'd63);
        send_pay(q, 1);
        wait_done();
        check("max_hdr", stream[0], 8'hFE);
        check("max_par", stream[64], 8'hC1);
        check("max_cycles", send_cycles, 65);
        check("max_count", pkt_count, 3);

        q = '{8'h11, 8'h22};
        r = '{8'h5A};
        send_cmd(2'd0, 6'd2);
        send_pay(q, 0);
        send_cmd(2'd2, 6'd1);
        send_pay(r, 0);
        wait_done();
        check("b2b_gap", last_gap >= GAP, 1);
        check("b2b_count", pkt_count, 5);

        rand_busy = 1;
        repeat (25) begin
            a = 2'($urandom);
            l = 6'($urandom_range(0, 12));
            send_cmd(a, l);
            if (a != 2'd3 && l != 6'd0) begin
                q.delete();
                for (int i = 0; i < int'(l); i++) q.push_back(8'($urandom));
                send_pay(q, ($urandom % 2) == 1);
                wait_done();
            end
        end
        rand_busy = 0;
        busy = 0;

        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_cmd(2'd1, 6'd5);
        send_pay(q, 0);
        tick();
        tick();
        resetn = 0;
        tick();
        check("midrst_pkt_valid", pkt_valid, 0);
        check("midrst_data_in", data_in, 0);
        check("midrst_cmd_ready", cmd_ready, 0);
        tick();
        resetn = 1;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_count", pkt_count, 0);
        check("post_rst_empty", dut.u_buf.empty, 1);
        check("post_rst_pl_ready", pl_ready, 0);

        r = '{8'h3C};
        send_cmd(2'd0, 6'd1);
        send_pay(r, 0);
        wait_done();
        check("recover_count", pkt_count, 1);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
